// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory sequencer: issues one request per instruction, freezes the
// upstream pipeline while the access is outstanding, and owns halt/error retirement.
module dmem_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en_EX_MEM,
  input  logic        mem_wr_EX_MEM,
  input  logic [15:0] alu_out_EX_MEM,
  input  logic [15:0] writedata_EX_MEM,
  input  logic        halt_EX_MEM,
  input  logic        dmem_done,
  input  logic        dmem_err,
  input  logic [15:0] dmem_rdata,
  output logic        dmem_rd,
  output logic        dmem_wr,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic [15:0] mem_rdata,
  output logic        pipe_stall,
  output logic        bubble_MEM_WB,
  output logic        halt_out,
  output logic        err_out,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_HALTED = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_act;

  assign dmem_addr  = alu_out_EX_MEM;
  assign dmem_wdata = writedata_EX_MEM;
  assign halt_out   = (state_q == S_HALTED);
  assign err_out    = (state_q == S_ERR);
  assign dbg_state  = state_q;
  assign mem_rdata  = (dmem_done && load_act) ? dmem_rdata : 16'h0000;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dmem_rd       = 1'b0;
    dmem_wr       = 1'b0;
    pipe_stall    = 1'b0;
    bubble_MEM_WB = 1'b0;
    load_act      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_en_EX_MEM) begin
          if (alu_out_EX_MEM[0]) begin
            state_d       = S_ERR;
            pipe_stall    = 1'b1;
            bubble_MEM_WB = 1'b1;
          end else begin
            dmem_rd  = ~mem_wr_EX_MEM;
            dmem_wr  = mem_wr_EX_MEM;
            load_act = ~mem_wr_EX_MEM;
            if (dmem_done) begin
              if (dmem_err) begin
                state_d       = S_ERR;
                pipe_stall    = 1'b1;
                bubble_MEM_WB = 1'b1;
              end else if (halt_EX_MEM) begin
                state_d = S_HALTED;
              end
            end else begin
              state_d       = S_WAIT;
              pipe_stall    = 1'b1;
              bubble_MEM_WB = 1'b1;
              cnt_d         = CNT_W'(1);
            end
          end
        end else if (halt_EX_MEM) begin
          // HALT itself retires, so no bubble this cycle.
          state_d = S_HALTED;
        end
      end
      S_WAIT: begin
        // The memory latched the request when it was issued; never reissue.
        load_act = ~mem_wr_EX_MEM;
        if (dmem_done) begin
          if (dmem_err) begin
            state_d       = S_ERR;
            pipe_stall    = 1'b1;
            bubble_MEM_WB = 1'b1;
          end else begin
            state_d = halt_EX_MEM ? S_HALTED : S_IDLE;
          end
        end else begin
          pipe_stall    = 1'b1;
          bubble_MEM_WB = 1'b1;
          if (cnt_q == CNT_W'(TIMEOUT)) state_d = S_ERR;
          else                          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        pipe_stall    = 1'b1;
        bubble_MEM_WB = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized bench for dmem_ctrl: a transaction-level model predicts every cycle's
// outputs from the access parameters (latency, error, halt, alignment).
module tb_dmem_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en_EX_MEM, mem_wr_EX_MEM, halt_EX_MEM;
  logic [15:0] alu_out_EX_MEM, writedata_EX_MEM;
  logic        dmem_done, dmem_err;
  logic [15:0] dmem_rdata;
  logic        dmem_rd, dmem_wr, pipe_stall, bubble_MEM_WB, halt_out, err_out;
  logic [15:0] dmem_addr, dmem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  dmem_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .mem_en_EX_MEM(mem_en_EX_MEM), .mem_wr_EX_MEM(mem_wr_EX_MEM),
    .alu_out_EX_MEM(alu_out_EX_MEM), .writedata_EX_MEM(writedata_EX_MEM),
    .halt_EX_MEM(halt_EX_MEM), .dmem_done(dmem_done), .dmem_err(dmem_err),
    .dmem_rdata(dmem_rdata), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .mem_rdata(mem_rdata),
    .pipe_stall(pipe_stall), .bubble_MEM_WB(bubble_MEM_WB),
    .halt_out(halt_out), .err_out(err_out), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  // Model status: 0 running, 1 halted, 2 errored (both sticky until reset).
  int mstat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input string tag, input logic erd, input logic ewr,
                             input logic estall, input logic ebub, input logic [15:0] erdata);
    @(negedge clk);
    check({tag, ".rd"},     32'(dmem_rd), 32'(erd));
    check({tag, ".wr"},     32'(dmem_wr), 32'(ewr));
    check({tag, ".stall"},  32'(pipe_stall), 32'(estall));
    check({tag, ".bubble"}, 32'(bubble_MEM_WB), 32'(ebub));
    check({tag, ".rdata"},  32'(mem_rdata), 32'(erdata));
    check({tag, ".halt"},   32'(halt_out), 32'(mstat == 1));
    check({tag, ".err"},    32'(err_out), 32'(mstat == 2));
    check({tag, ".addr"},   32'(dmem_addr), 32'(alu_out_EX_MEM));
    check({tag, ".wdata"},  32'(dmem_wdata), 32'(writedata_EX_MEM));
    check({tag, ".rdwr"},   32'(dmem_rd & dmem_wr), 32'(0));
  endtask

  task automatic drive_quiet();
    mem_en_EX_MEM = 1'b0; mem_wr_EX_MEM = 1'b0; halt_EX_MEM = 1'b0;
    dmem_done = 1'b0; dmem_err = 1'b0;
  endtask

  // One memory instruction in MEM. lat = cycles before dmem_done (0 = hit);
  // lat > TIMEOUT means the memory never answers.
  task automatic do_access(input string tag, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input int lat, input logic err,
                           input logic halt);
    int last;
    logic done, comp;
    logic [15:0] rdata, erdata;
    mem_en_EX_MEM = 1'b1; mem_wr_EX_MEM = wr; alu_out_EX_MEM = addr;
    writedata_EX_MEM = wdata; halt_EX_MEM = halt;
    if (addr[0]) begin
      dmem_done = 1'b0; dmem_err = 1'b0; dmem_rdata = 16'($urandom);
      check_cycle({tag, ".mis"}, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
      step();
      mstat = 2;
    end else begin
      last = (lat > TIMEOUT) ? TIMEOUT : lat;
      for (int k = 0; k <= last; k++) begin
        done = (k == lat);
        rdata = 16'($urandom);
        dmem_done = done; dmem_err = done & err; dmem_rdata = rdata;
        comp = done & ~err;
        if (done && !wr) exp_q.push_back(rdata);
        erdata = (done && !wr) ? exp_q.pop_front() : 16'h0000;
        check_cycle(tag, (k == 0) & ~wr, (k == 0) & wr, ~comp, ~comp, erdata);
        step();
      end
      if (lat > TIMEOUT || err) mstat = 2;
      else if (halt)            mstat = 1;
    end
    drive_quiet();
  endtask

  // Cycle with no memory instruction; in a sticky state the inputs are noise.
  task automatic idle_cycle(input string tag, input logic halt);
    drive_quiet();
    halt_EX_MEM = halt;
    dmem_rdata = 16'($urandom);
    if (mstat != 0) begin
      mem_en_EX_MEM = 1'($urandom); mem_wr_EX_MEM = 1'($urandom);
      alu_out_EX_MEM = 16'($urandom); dmem_done = 1'($urandom);
      check_cycle(tag, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    end else begin
      check_cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      if (halt) mstat = 1;
    end
    step();
  endtask

  task automatic do_reset();
    drive_quiet();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mstat = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mstat = 0;
    drive_quiet();
    alu_out_EX_MEM = 16'h0000; writedata_EX_MEM = 16'h0000; dmem_rdata = 16'h0000;
    step(); step();
    rst = 1'b0;
    idle_cycle("reset", 1'b0);

    // Load hit, then store with three cycles of latency.
    do_access("load_hit", 1'b0, 16'h0010, 16'h0000, 0, 1'b0, 1'b0);
    do_access("store_miss", 1'b1, 16'h0020, 16'h1234, 3, 1'b0, 1'b0);
    idle_cycle("after_store", 1'b0);

    // Misaligned load: error is sticky until reset.
    do_access("misalign", 1'b0, 16'h0021, 16'h0000, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle_cycle("mis_sticky", 1'b0);
    do_reset();
    idle_cycle("mis_reset", 1'b0);

    // Memory never answers.
    do_access("timeout", 1'b0, 16'h0030, 16'h0000, 1000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle_cycle("to_sticky", 1'b0);
    do_reset();

    // Halt holds for 100 cycles.
    idle_cycle("halt", 1'b1);
    for (int i = 0; i < 100; i++) idle_cycle("halted", 1'b1);
    do_reset();
    idle_cycle("halt_reset", 1'b0);

    // Reset during the second WAIT cycle, then a fresh hit.
    mem_en_EX_MEM = 1'b1; mem_wr_EX_MEM = 1'b0; alu_out_EX_MEM = 16'h0040;
    dmem_done = 1'b0; dmem_err = 1'b0;
    check_cycle("rst_mid0", 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
    step();
    check_cycle("rst_mid1", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    step();
    rst = 1'b1;
    check_cycle("rst_mid2", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    step();
    rst = 1'b0;
    do_access("rst_fresh", 1'b0, 16'h0042, 16'h0000, 0, 1'b0, 1'b0);

    // Error on completion, both from a hit and from a wait.
    do_access("err_hit", 1'b1, 16'h0050, 16'hAAAA, 0, 1'b1, 1'b0);
    idle_cycle("err_hit_st", 1'b0);
    do_reset();
    do_access("err_wait", 1'b0, 16'h0052, 16'h0000, 2, 1'b1, 1'b1);
    idle_cycle("err_wait_st", 1'b1);
    do_reset();

    // Halt on a completing access.
    do_access("halt_acc", 1'b0, 16'h0060, 16'h0000, 2, 1'b0, 1'b1);
    idle_cycle("halt_acc_st", 1'b1);
    do_reset();

    // Random mix.
    for (int n = 0; n < 200; n++) begin
      int r;
      logic [15:0] a;
      if (mstat != 0) begin
        for (int i = 0; i < $urandom_range(1, 3); i++) idle_cycle("rnd_sticky", 1'b0);
        do_reset();
        continue;
      end
      r = $urandom_range(0, 19);
      a = 16'($urandom) & 16'hFFFE;
      if (r < 2)       idle_cycle("rnd_idle", 1'b0);
      else if (r == 2) idle_cycle("rnd_halt", 1'b1);
      else if (r == 3) do_access("rnd_mis", 1'($urandom), a | 16'h0001, 16'($urandom), 0, 1'b0, 1'b0);
      else             do_access("rnd_acc", 1'($urandom), a, 16'($urandom),
                                 $urandom_range(0, 5), ($urandom_range(0, 9) == 0),
                                 ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
